// File: rtl/hdmi_pattern_generator.sv
`default_nettype none
// hdmi_pattern_generator: VGA/HDMI raster timing plus checkerboard, colour-bar, gradient and solid test patterns.
// Revision 1.0
module hdmi_pattern_generator #(
  parameter int COLOR_WIDTH  = 8,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit SYNC_POL     = 1'b0,
  parameter int CHECKER_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [3*COLOR_WIDTH-1:0]   solid_color,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       de,
  output logic [11:0]                cx,
  output logic [11:0]                cy,
  output logic [3*COLOR_WIDTH-1:0]   rgb,
  output logic                       frame_start
);

  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] H_SYNC_LO = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_HI = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] V_SYNC_LO = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_HI = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam int          BAR_W     = H_ACTIVE / 8;
  localparam logic [COLOR_WIDTH-1:0] ONES = {COLOR_WIDTH{1'b1}};

  logic [1:0]               rst_sync_q, rst_sync_d;
  logic                     run_q, run_d;
  logic [11:0]              h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]               mode_q, mode_d;
  logic [3*COLOR_WIDTH-1:0] solid_q, solid_d;
  logic                     hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [11:0]              cx_q, cx_d, cy_q, cy_d;
  logic [3*COLOR_WIDTH-1:0] rgb_q, rgb_d;
  logic                     frame_start_q, frame_start_d;

  logic                     en_now, frame_origin, active, checker_on, past_bars;
  logic [2:0]               bar_idx;
  logic [2:0]               bar_bits;
  logic [COLOR_WIDTH-1:0]   hv_sum;
  logic [3*COLOR_WIDTH-1:0] pixel;

  // run_q delays a fresh enable by one clock so the counters see one clean cycle at the origin.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    run_d      = enable & rst_sync_q[1];
    en_now     = enable & run_q;
    h_cnt_d    = 12'd0;
    v_cnt_d    = 12'd0;
    if (en_now) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 12'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  // The origin pixel already uses the freshly latched frame settings.
  always_comb begin
    frame_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    mode_d       = frame_origin ? mode : mode_q;
    solid_d      = frame_origin ? solid_color : solid_q;
  end

  always_comb begin
    active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    checker_on = h_cnt_q[CHECKER_LOG2] ^ v_cnt_q[CHECKER_LOG2];
    hv_sum     = h_cnt_q[COLOR_WIDTH-1:0] + v_cnt_q[COLOR_WIDTH-1:0];
    bar_idx    = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= 12'(i * BAR_W)) bar_idx = 3'(i);
    end
    past_bars = (h_cnt_q >= 12'(8 * BAR_W));
    case (bar_idx)
      3'd0:    bar_bits = 3'b111;
      3'd1:    bar_bits = 3'b110;
      3'd2:    bar_bits = 3'b011;
      3'd3:    bar_bits = 3'b010;
      3'd4:    bar_bits = 3'b101;
      3'd5:    bar_bits = 3'b100;
      3'd6:    bar_bits = 3'b001;
      default: bar_bits = 3'b000;
    endcase
    if (past_bars) bar_bits = 3'b000;
    case (mode_d)
      2'd0:    pixel = checker_on ? {3{ONES}} : '0;
      2'd1:    pixel = {bar_bits[2] ? ONES : '0, bar_bits[1] ? ONES : '0, bar_bits[0] ? ONES : '0};
      2'd2:    pixel = {h_cnt_q[COLOR_WIDTH-1:0], v_cnt_q[COLOR_WIDTH-1:0], hv_sum};
      default: pixel = solid_d;
    endcase
  end

  always_comb begin
    de_d          = en_now & active;
    cx_d          = de_d ? h_cnt_q : 12'd0;
    cy_d          = de_d ? v_cnt_q : 12'd0;
    rgb_d         = de_d ? pixel : '0;
    frame_start_d = de_d & frame_origin;
    hsync_d       = (en_now && h_cnt_q >= H_SYNC_LO && h_cnt_q <= H_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (en_now && v_cnt_q >= V_SYNC_LO && v_cnt_q <= V_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rst_sync_q    <= 2'b00;
      run_q         <= 1'b0;
      h_cnt_q       <= 12'd0;
      v_cnt_q       <= 12'd0;
      mode_q        <= 2'd0;
      solid_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      cx_q          <= 12'd0;
      cy_q          <= 12'd0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      rst_sync_q    <= rst_sync_d;
      run_q         <= run_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      solid_q       <= solid_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign cx          = cx_q;
  assign cy          = cy_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pattern_generator.sv
`default_nettype none
// tb_hdmi_pattern_generator: directed checks of timing, patterns, frame latching, enable and reset behaviour.
// Revision 1.0
module tb_hdmi_pattern_generator;

  logic        clk = 1'b0;
  logic        aresetn, enable;
  logic [1:0]  mode, mode2;
  logic [23:0] solid_color;
  logic        hs1, vs1, de1, fs1;
  logic [11:0] cx1, cy1;
  logic [23:0] rgb1;
  logic        hs2, vs2, de2, fs2;
  logic [11:0] cx2, cy2;
  logic [11:0] rgb2;
  int          errors = 0;
  int          checks = 0;
  int          n;

  always #5 clk = ~clk;

  // Full-width line, short frame so several frames fit in the run.
  hdmi_pattern_generator #(
    .COLOR_WIDTH(8), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .CHECKER_LOG2(3)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .mode(mode), .solid_color(solid_color),
    .hsync(hs1), .vsync(vs1), .de(de1), .cx(cx1), .cy(cy1), .rgb(rgb1), .frame_start(fs1)
  );

  hdmi_pattern_generator #(
    .COLOR_WIDTH(4), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0), .CHECKER_LOG2(3)
  ) dut_grad (
    .clk(clk), .aresetn(aresetn), .enable(enable), .mode(mode2), .solid_color(solid_color[11:0]),
    .hsync(hs2), .vsync(vs2), .de(de2), .cx(cx2), .cy(cy2), .rgb(rgb2), .frame_start(fs2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    aresetn = 1'b1; enable = 1'b0; mode = 2'd0; mode2 = 2'd2; solid_color = 24'h0;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_hsync", {31'd0, hs1}, 32'd1);
    chk("rst_vsync", {31'd0, vs1}, 32'd1);
    chk("rst_de", {31'd0, de1}, 32'd0);
    chk("rst_cx_cy", {8'd0, cx1, cy1}, 32'd0);
    chk("rst_rgb", {8'd0, rgb1}, 32'd0);
    chk("rst_fs", {31'd0, fs1}, 32'd0);
    step(2);
    aresetn = 1'b1; mode = 2'd1; enable = 1'b1;

    n = 0;
    while (fs1 !== 1'b1 && n < 20) begin step(1); n++; end
    chk("start_fs_seen", {31'd0, fs1}, 32'd1);
    chk("start_not_early", {31'd0, n >= 2}, 32'd1);
    chk("bar_cx0_pos", {8'd0, cx1, cy1}, 32'd0);
    chk("bar_cx0", {8'd0, rgb1}, 32'hFFFFFF);
    step(70);
    chk("grad_blank", {20'd0, rgb2}, 32'h0);
    step(10);
    chk("bar_cx80_pos", {20'd0, cx1}, 32'd80);
    chk("bar_cx80", {8'd0, rgb1}, 32'hFFFF00);
    step(80);
    chk("bar_cx160", {8'd0, rgb1}, 32'h00FFFF);
    step(97);
    chk("grad_pos", {8'd0, cx2, cy2}, {8'd0, 12'd17, 12'd3});
    chk("grad_rgb", {20'd0, rgb2}, 32'h134);
    step(143);
    chk("bar_cx400", {8'd0, rgb1}, 32'hFF0000);
    step(239);
    chk("bar_cx639_de", {31'd0, de1}, 32'd1);
    chk("bar_cx639", {8'd0, rgb1}, 32'h000000);
    step(1);
    chk("blank_de", {31'd0, de1}, 32'd0);
    chk("blank_rgb_cx", {8'd0, rgb1}, 32'd0);
    chk("blank_cx", {20'd0, cx1}, 32'd0);
    step(15);
    chk("hs_655", {31'd0, hs1}, 32'd1);
    step(1);
    chk("hs_656", {31'd0, hs1}, 32'd0);
    step(95);
    chk("hs_751", {31'd0, hs1}, 32'd0);
    step(1);
    chk("hs_752", {31'd0, hs1}, 32'd1);
    step(48);
    chk("line2_pos", {7'd0, de1, cx1, cy1}, {7'd0, 1'b1, 12'd0, 12'd1});
    chk("line2_bar", {8'd0, rgb1}, 32'hFFFFFF);
    mode = 2'd0;
    step(80);
    chk("mode_held_bars", {8'd0, rgb1}, 32'hFFFF00);
    step(7919);
    chk("vs_before", {31'd0, vs1}, 32'd1);
    step(1);
    chk("vs_first", {31'd0, vs1}, 32'd0);
    step(1599);
    chk("vs_last", {31'd0, vs1}, 32'd0);
    step(1);
    chk("vs_after", {31'd0, vs1}, 32'd1);
    step(800);
    chk("frame2_fs", {31'd0, fs1}, 32'd1);
    chk("chk_0_0", {8'd0, rgb1}, 32'h000000);
    step(8);
    chk("chk_8_0", {8'd0, rgb1}, 32'hFFFFFF);
    mode = 2'd3; solid_color = 24'h123456;
    step(6400);
    chk("chk_8_8_pos", {8'd0, cx1, cy1}, {8'd0, 12'd8, 12'd8});
    chk("chk_8_8", {8'd0, rgb1}, 32'h000000);
    step(8);
    chk("chk_16_8", {8'd0, rgb1}, 32'hFFFFFF);
    step(4784);
    chk("frame3_fs", {31'd0, fs1}, 32'd1);
    chk("solid_frame3", {8'd0, rgb1}, 32'h123456);

    step(4100);
    chk("en_drop_pos", {8'd0, cx1, cy1}, {8'd0, 12'd100, 12'd5});
    enable = 1'b0;
    step(1);
    chk("en_drop_de", {31'd0, de1}, 32'd0);
    chk("en_drop_rgb", {8'd0, rgb1}, 32'd0);
    solid_color = 24'h00FF00;
    step(3);
    enable = 1'b1;
    step(1);
    chk("reen_fs_c1", {31'd0, fs1}, 32'd0);
    step(1);
    chk("reen_fs_c2", {31'd0, fs1}, 32'd1);
    chk("reen_relatch", {8'd0, rgb1}, 32'h00FF00);

    step(5600);
    chk("pre_rst_pos", {7'd0, de1, cx1, cy1}, {7'd0, 1'b1, 12'd0, 12'd7});
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst_de", {31'd0, de1}, 32'd0);
    chk("async_rst_rgb", {8'd0, rgb1}, 32'd0);
    chk("async_rst_cy", {20'd0, cy1}, 32'd0);
    step(2);
    aresetn = 1'b1;
    n = 0;
    while (de1 !== 1'b1 && n < 20) begin step(1); n++; end
    chk("post_rst_de_seen", {31'd0, de1}, 32'd1);
    chk("post_rst_first_de_fs", {31'd0, fs1}, 32'd1);
    chk("post_rst_origin", {8'd0, cx1, cy1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdmi_pattern_generator.md
HDMI_PATTERN_GENERATOR -- requirements
Module: hdmi_pattern_generator

Interface
REQ-001 SHALL have parameter COLOR_WIDTH, default 8, bits per colour channel (4..12).
REQ-002 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-005 SHALL have parameter CHECKER_LOG2, default 3, log2 of checkerboard square size in pixels.
REQ-006 SHALL have ports:
clk  input  1  pixel clock, sole clock domain.
aresetn  input  1  asynchronous active-low reset.
enable  input  1  run timing generator.
mode  input  2  pattern select: 0 checkerboard, 1 colour bars, 2 gradient, 3 solid.
solid_color  input  3*COLOR_WIDTH  {R,G,B} for mode 3.
hsync  output  1  horizontal sync.
vsync  output  1  vertical sync.
de  output  1  data enable, high in active area.
cx  output  12  active pixel column.
cy  output  12  active line.
rgb  output  3*COLOR_WIDTH  {R,G,B} pixel.
frame_start  output  1  one-cycle pulse on first active pixel of frame.

Function
REQ-007 SHALL keep internal counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1; H_TOTAL = sum of H params, V_TOTAL = sum of V params.
REQ-008 SHALL increment h_cnt each clk while enable=1; at H_TOTAL-1 wrap to 0 and increment v_cnt; v_cnt wraps V_TOTAL-1 -> 0 on same cycle as h_cnt wrap.
REQ-009 SHALL order each line/frame as active, front porch, sync, back porch; active = h_cnt < H_ACTIVE (v_cnt < V_ACTIVE).
REQ-010 SHALL assert hsync (level SYNC_POL inverted when idle) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync likewise on v_cnt, independent of h_cnt.
REQ-011 SHALL register all outputs; outputs at cycle n+1 reflect counters at cycle n (latency 1, all outputs mutually aligned).
REQ-012 SHALL drive cx=h_cnt, cy=v_cnt when de=1; cx, cy hold 0 when de=0.
REQ-013 SHALL drive rgb=0 whenever de=0.
REQ-014 SHALL latch mode and solid_color into a frame register only when h_cnt=0 and v_cnt=0; mid-frame changes take effect next frame.
REQ-015 Mode 0 SHALL output all-ones when cx[CHECKER_LOG2] XOR cy[CHECKER_LOG2] = 1, else all-zeros.
REQ-016 Mode 1 SHALL split H_ACTIVE into 8 equal bars (width H_ACTIVE/8, integer), left-to-right white, yellow, cyan, green, magenta, red, blue, black, channel values all-ones or zero; remainder pixels past bar 7 black.
REQ-017 Mode 2 SHALL output R = cx[COLOR_WIDTH-1:0], G = cy[COLOR_WIDTH-1:0], B = (cx+cy) truncated to COLOR_WIDTH bits.
REQ-018 Mode 3 SHALL output latched solid_color.
REQ-019 SHALL pulse frame_start for exactly one cycle with de=1, cx=0, cy=0.
REQ-020 When enable=0, counters SHALL reset to 0 on next clk and outputs SHALL go to idle values; on re-enable the frame restarts at h_cnt=0, v_cnt=0 with mode re-latched.

Reset
REQ-021 aresetn=0 SHALL asynchronously clear counters, latched mode (0), latched colour (0) and drive hsync=vsync=~SYNC_POL, de=0, cx=cy=0, rgb=0, frame_start=0.
REQ-022 Reset deassertion SHALL be synchronised internally; first counter increment occurs no earlier than the second clk edge after aresetn rises.
REQ-023 Reset asserted mid-frame SHALL abort the frame; no partial-line state survives.

Verification
REQ-024 Defaults, enable=1: hsync low for exactly 96 cycles starting 656 cycles after line's first de; line period 800 cycles; frame period 420000 cycles; vsync low for 1600 cycles.
REQ-025 Mode 1, 24-bit: cx=0 -> rgb=FFFFFF, cx=80 -> FFFF00, cx=160 -> 00FFFF, cx=400 -> FF0000, cx=639 -> 000000; blanking -> 000000.
REQ-026 Mode 0, CHECKER_LOG2=3: (cx,cy)=(0,0) -> 000000, (8,0) -> FFFFFF, (8,8) -> 000000; mode switched to 3 mid-frame -> pattern unchanged until next frame_start, then solid_color.
REQ-027 enable dropped at cx=100, cy=50 -> de=0, rgb=0 next cycle; re-enable -> frame_start after exactly 2 cycles (1 counter + 1 output latency).
REQ-028 aresetn pulsed low at cy=200 -> outputs at REQ-021 values immediately (no clk); after release, frame_start precedes any other de=1.
REQ-029 COLOR_WIDTH=4, H_ACTIVE=64, mode 2: cx=17, cy=3 -> rgb = {1,3,4} per 4-bit channel.
